// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and defaults for the shared-register write arbiter.
package shared_reg_arbiter_pkg;

  localparam int unsigned DefaultNreq = 4;
  localparam int unsigned DefaultW    = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StAck  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/shared_reg_arbiter_register.sv
// The shared enabled storage register: loads din_i on clk when en_i is high.
module shared_reg_arbiter_register
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] qout_o
);

  logic [W-1:0] qout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qout_q <= '0;
    end else if (en_i) begin
      qout_q <= din_i;
    end
  end

  assign qout_o = qout_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter: grants one requester, writes the shared register for one
// cycle, then pulses ack to that requester.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq,
  parameter int unsigned W    = DefaultW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic              busy_o,
  output logic [W-1:0]      qout_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e      state_q;
  logic [IdxW-1:0] winner_q;
  logic [IdxW-1:0] last_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] ack_q;
  logic            busy_q;

  // First requester after last, wrapping modulo NREQ; last itself is checked last.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IdxW-1:0] last);
    logic [IdxW-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(last) + off) % NREQ;
      if (!found && r[idx]) begin
        pick  = IdxW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [NREQ-1:0] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  logic [IdxW-1:0] pick;
  assign pick = rr_pick(req_i, last_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      winner_q <= '0;
      last_q   <= IdxW'(NREQ - 1);
      gnt_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            winner_q <= pick;
            last_q   <= pick;
            gnt_q    <= onehot(pick);
            busy_q   <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          // Committed: completes even if the winner has dropped its request.
          gnt_q   <= '0;
          ack_q   <= onehot(winner_q);
          state_q <= StAck;
        end
        StAck: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  logic         reg_en;
  logic [W-1:0] reg_din;

  assign reg_en  = (state_q == StLoad);
  assign reg_din = wdata_i[32'(winner_q)*W +: W];

  shared_reg_arbiter_register #(
    .W(W)
  ) u_register (
    .clk   (clk),
    .rst   (rst),
    .en_i  (reg_en),
    .din_i (reg_din),
    .qout_o(qout_o)
  );

  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign busy_o = busy_q;

endmodule
